// File: rtl/branch_history_table_pkg.sv
// Shared constants for the branch history table: opcode, 2-bit counter
// encodings and the FSM state encoding.
package branch_history_table_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bht_state_e;

endpackage

// File: rtl/branch_history_table_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import branch_history_table_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken && (cur != CNT_ST))
      nxt = cur + 2'd1;
    else if (!taken && (cur != CNT_SNT))
      nxt = cur - 2'd1;
  end

endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped table of 2-bit counters predicting branch direction at fetch
// and training on resolved outcomes; sweeps every entry to WNT after reset.
//
//   state | meaning
//   INIT  | writing WNT to entry r_init_idx, one entry per cycle
//   RUN   | predicting, training and counting statistics
module branch_history_table
  import branch_history_table_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ready,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic [6:0]       fetch_opcode,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             resolve_valid,
  input  logic [31:0]      resolve_pc,
  input  logic             resolve_taken,
  input  logic             resolve_pred_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          r_table [ENTRIES];
  bht_state_e          r_state;
  bht_state_e          w_state_nxt;
  logic [IDX_BITS-1:0] r_init_idx;
  logic                r_pred_valid;
  logic                r_pred_taken;
  logic [CNT_W-1:0]    r_branch_count;
  logic [CNT_W-1:0]    r_mispredict_count;

  logic [IDX_BITS-1:0] w_fetch_idx;
  logic [IDX_BITS-1:0] w_res_idx;
  logic                w_run;
  logic                w_train;
  logic [1:0]          w_train_cnt;
  logic                w_we;
  logic [IDX_BITS-1:0] w_waddr;
  logic [1:0]          w_wdata;
  logic [1:0]          w_rd_cnt;
  logic                w_pred_valid_nxt;
  logic                w_unused_bits;

  assign w_fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign w_res_idx   = resolve_pc[IDX_BITS+1:2];
  assign w_run       = (r_state == ST_RUN);
  assign w_train     = w_run & resolve_valid;
  assign mispredict  = resolve_valid & (resolve_taken != resolve_pred_taken);

  assign w_unused_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                           resolve_pc[31:IDX_BITS+2], resolve_pc[1:0]};

  sat_counter2 u_sat_counter2 (
    .cur   (r_table[w_res_idx]),
    .taken (resolve_taken),
    .nxt   (w_train_cnt)
  );

  // Single write port: the init sweep owns it in INIT, training in RUN.
  assign w_we    = rst_n & (!w_run | w_train);
  assign w_waddr = w_run ? w_res_idx : r_init_idx;
  assign w_wdata = w_run ? w_train_cnt : CNT_WNT;

  always_ff @(posedge clk) begin
    if (w_we)
      r_table[w_waddr] <= w_wdata;
  end

  // Write-first bypass when the resolve trains the entry being fetched.
  assign w_rd_cnt = (w_train && (w_res_idx == w_fetch_idx)) ? w_train_cnt
                                                            : r_table[w_fetch_idx];
  assign w_pred_valid_nxt = w_run & fetch_valid & (fetch_opcode == OPC_BRANCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_run)
        r_init_idx <= r_init_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_idx == {IDX_BITS{1'b1}}) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    ready = (r_state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pred_valid       <= 1'b0;
      r_pred_taken       <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_pred_valid <= w_pred_valid_nxt;
      r_pred_taken <= w_pred_valid_nxt & w_rd_cnt[1];
      if (w_train && (r_branch_count != {CNT_W{1'b1}}))
        r_branch_count <= r_branch_count + 1'b1;
      if (w_run && mispredict && (r_mispredict_count != {CNT_W{1'b1}}))
        r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign pred_valid       = r_pred_valid;
  assign pred_taken       = r_pred_taken;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table: init sweep, prediction, training,
// bypass, aliasing, statistics saturation (narrow instance) and mid-run reset.
module tb_branch_history_table;
  import branch_history_table_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [6:0]  fetch_opcode;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic        resolve_pred_taken;

  logic        ready, pred_valid, pred_taken, mispredict;
  logic [31:0] branch_count, mispredict_count;
  logic        s_ready, s_pred_valid, s_pred_taken, s_mispredict;
  logic [2:0]  s_branch_count, s_mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_history_table u_dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_opcode(fetch_opcode),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_pred_taken(resolve_pred_taken),
    .mispredict(mispredict), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_history_table #(.IDX_BITS(6), .CNT_W(3)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .ready(s_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_opcode(fetch_opcode),
    .pred_valid(s_pred_valid), .pred_taken(s_pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_pred_taken(resolve_pred_taken),
    .mispredict(s_mispredict), .branch_count(s_branch_count),
    .mispredict_count(s_mispredict_count)
  );

  typedef struct packed {
    logic        fv;
    logic [31:0] fpc;
    logic [6:0]  fop;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic        rpt;
    logic        e_pv;
    logic        e_pt;
    logic        e_mp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = 1'b0; fetch_pc = '0; fetch_opcode = '0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_pred_taken = 1'b0;
  endtask

  // Counts cycles with ready low, starting from the current cycle.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic sweep_cold(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      fetch_valid = 1'b1; fetch_opcode = OPC_BRANCH; fetch_pc = 32'(i) << 2;
      step();
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0) bad++;
    end
    idle();
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h100, OPC_BRANCH, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h100, 7'h13,      1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   OPC_BRANCH, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 32'h100, OPC_BRANCH, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,   OPC_BRANCH, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,   OPC_BRANCH, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,   OPC_BRANCH, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h100, OPC_BRANCH, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,   OPC_BRANCH, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 32'h100, OPC_BRANCH, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h104, OPC_BRANCH, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 32'h108, OPC_BRANCH, 1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 32'h104, OPC_BRANCH, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,   OPC_BRANCH, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 32'h100, OPC_BRANCH, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h100, OPC_BRANCH, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    idle();
    repeat (3) step();
    check("rst_ready",      32'(ready), 32'd0);
    check("rst_pred_valid", 32'(pred_valid), 32'd0);
    check("rst_pred_taken", 32'(pred_taken), 32'd0);
    check("rst_branch_cnt", branch_count, 32'd0);
    check("rst_mispred_cnt", mispredict_count, 32'd0);
    check("rst_mispredict", 32'(mispredict), 32'd0);

    rst_n = 1'b1;
    wait_ready(n);
    check("init_ready_low_cycles", 32'(n), 32'd64);
    check("init_ready_high", 32'(ready), 32'd1);
    sweep_cold("init_all_entries_wnt");

    for (int i = 0; i < NVEC; i++) begin
      fetch_valid = vecs[i].fv; fetch_pc = vecs[i].fpc; fetch_opcode = vecs[i].fop;
      resolve_valid = vecs[i].rv; resolve_pc = vecs[i].rpc;
      resolve_taken = vecs[i].rt; resolve_pred_taken = vecs[i].rpt;
      #1;
      check($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].e_mp));
      step();
      check($sformatf("vec%0d_pred_valid", i), 32'(pred_valid), 32'(vecs[i].e_pv));
      check($sformatf("vec%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
    end
    idle();
    check("vec_branch_cnt",        branch_count, 32'd8);
    check("vec_mispred_cnt",       mispredict_count, 32'd5);
    check("small_branch_cnt_sat",  32'(s_branch_count), 32'd7);
    check("small_mispred_cnt",     32'(s_mispredict_count), 32'd5);

    // Aliased mispredicts: one increment each, narrow counter saturates at 7.
    for (int k = 0; k < 3; k++) begin
      resolve_valid = 1'b1; resolve_pc = 32'h200; resolve_taken = 1'b0; resolve_pred_taken = 1'b1;
      #1;
      check($sformatf("alias%0d_mispredict", k), 32'(mispredict), 32'd1);
      step();
      check($sformatf("alias%0d_mispred_cnt", k), mispredict_count, 32'(6 + k));
      check($sformatf("alias%0d_small_cnt", k), 32'(s_mispredict_count), (k == 0) ? 32'd6 : 32'd7);
    end
    idle();
    check("alias_branch_cnt", branch_count, 32'd11);

    // Mid-run reset pulse, then resolves during the re-init sweep.
    rst_n = 1'b0;
    step();
    check("mrst_ready",       32'(ready), 32'd0);
    check("mrst_branch_cnt",  branch_count, 32'd0);
    check("mrst_mispred_cnt", mispredict_count, 32'd0);
    check("mrst_pred_valid",  32'(pred_valid), 32'd0);
    rst_n = 1'b1;
    resolve_valid = 1'b1; resolve_pc = 32'h100; resolve_taken = 1'b1; resolve_pred_taken = 1'b0;
    #1;
    check("init_mispredict_driven", 32'(mispredict), 32'd1);
    wait_ready(n);
    idle();
    check("reinit_ready_low_cycles", 32'(n), 32'd64);
    check("reinit_branch_cnt",  branch_count, 32'd0);
    check("reinit_mispred_cnt", mispredict_count, 32'd0);
    sweep_cold("reinit_all_entries_wnt");

    // One taken update from WNT must reach WT (not SNT->WNT).
    resolve_valid = 1'b1; resolve_pc = 32'h100; resolve_taken = 1'b1; resolve_pred_taken = 1'b0;
    step();
    idle();
    fetch_valid = 1'b1; fetch_pc = 32'h100; fetch_opcode = OPC_BRANCH;
    step();
    idle();
    check("reinit_entry0_trains_taken", 32'(pred_taken), 32'd1);
    check("reinit_branch_cnt_run", branch_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
